// File: rtl/neander_div_pkg.sv
// Shared types for the NEANDER-X sequential divider.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: state_t, the FSM encoding shared with the shift-and-add multiplier.
package neander_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Start/busy/done handshake bundle between the ALU and the sequential divider.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the divider is idle.
// Ports: master = requester (drives start and operands), slave = divider (drives results and flags).
interface sequential_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend_high;
    logic [WIDTH-1:0] dividend_low;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend_high, dividend_low, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend_high, dividend_low, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: {dividend_high,dividend_low} / divisor -> WIDTH-bit quotient and remainder.
// Latency: WIDTH busy cycles then a one-cycle done pulse; error cases pulse done the cycle after start.
// Backpressure: start is sampled only in IDLE; start during DIVIDE/FINISH is dropped, not queued.
// Ports: clk, reset_n (async active-low), bus (slave side of sequential_divider_if).
module sequential_divider
    import neander_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sequential_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count;
    logic             dz_q;
    logic             ov_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor. Because rem_q < dvs_q is
    // invariant, the shifted value is below 2*divisor, so a non-negative
    // difference always fits in WIDTH bits and trial[WIDTH] is a clean sign.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_nxt = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            count <= '0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            state <= FINISH;
                            dz_q  <= 1'b1;
                            ov_q  <= 1'b0;
                            quo_q <= '1;
                            rem_q <= bus.dividend_low;
                        end else if (bus.dividend_high >= bus.divisor) begin
                            // Quotient would need more than WIDTH bits.
                            state <= FINISH;
                            dz_q  <= 1'b0;
                            ov_q  <= 1'b1;
                            quo_q <= '1;
                            rem_q <= bus.dividend_low;
                        end else begin
                            state <= DIVIDE;
                            dz_q  <= 1'b0;
                            ov_q  <= 1'b0;
                            rem_q <= bus.dividend_high;
                            quo_q <= bus.dividend_low;
                            dvs_q <= bus.divisor;
                            count <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.busy        = (state == DIVIDE);
    assign bus.done        = (state == FINISH);
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases plus a random sweep.
// Stimulus pushes expected results into a scoreboard; a negedge monitor pops on done.
// Expected values come from constants or a plain-arithmetic reference model.
module tb_sequential_divider;

    localparam int W = 8;

    logic clk;
    logic reset_n;

    sequential_divider_if #(.WIDTH(W)) bus ();

    sequential_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int dz;
        int ov;
        int lat;
        int dividend;
        int dv;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_run = 0;
    int   prev_done = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole-number division on the 16-bit dividend.
    function automatic exp_t ref_div(input int hi, input int lo, input int dv);
        exp_t e;
        e.dividend = hi * 256 + lo;
        e.dv       = dv;
        if (dv == 0) begin
            e.q = 255; e.r = lo; e.dz = 1; e.ov = 0; e.lat = 0;
        end else if (hi >= dv) begin
            e.q = 255; e.r = lo; e.dz = 0; e.ov = 1; e.lat = 0;
        end else begin
            e.q = e.dividend / dv; e.r = e.dividend % dv; e.dz = 0; e.ov = 0; e.lat = W;
        end
        return e;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_run  = 0;
            prev_done = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                check("busy_done_overlap", int'(bus.busy), 0);
                check("done_one_cycle", prev_done, 0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("quotient", int'(bus.quotient), e.q);
                    check("remainder", int'(bus.remainder), e.r);
                    check("div_by_zero", int'(bus.div_by_zero), e.dz);
                    check("overflow", int'(bus.overflow), e.ov);
                    check("busy_cycles", busy_run, e.lat);
                    if (e.dz == 0 && e.ov == 0) begin
                        check("identity", int'(bus.quotient) * e.dv + int'(bus.remainder), e.dividend);
                        check("rem_lt_div", int'(int'(bus.remainder) < e.dv), 1);
                    end
                end
                busy_run = 0;
            end
            prev_done = int'(bus.done);
        end
    end

    // Returns at a negedge where the divider is idle.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0d done=%0d expected idle", bus.busy, bus.done);
        end
    endtask

    task automatic drive_start(input int hi, input int lo, input int dv);
        bus.dividend_high = hi[7:0];
        bus.dividend_low  = lo[7:0];
        bus.divisor       = dv[7:0];
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
    endtask

    task automatic issue(input int hi, input int lo, input int dv);
        wait_idle();
        sb.push_back(ref_div(hi, lo, dv));
        drive_start(hi, lo, dv);
    endtask

    task automatic issue_exp(input int hi, input int lo, input int dv,
                             input int q, input int r, input int dz, input int ov);
        exp_t e;
        wait_idle();
        e.q = q; e.r = r; e.dz = dz; e.ov = ov;
        e.lat = (dz != 0 || ov != 0) ? 0 : W;
        e.dividend = hi * 256 + lo;
        e.dv = dv;
        sb.push_back(e);
        drive_start(hi, lo, dv);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_quotient"}, int'(bus.quotient), 0);
        check({tag, "_remainder"}, int'(bus.remainder), 0);
        check({tag, "_div_by_zero"}, int'(bus.div_by_zero), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    initial begin
        int n;
        reset_n           = 1'b0;
        bus.start         = 1'b0;
        bus.dividend_high = '0;
        bus.dividend_low  = '0;
        bus.divisor       = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Directed cases.
        issue_exp(8'h00, 8'hC8, 8'h07, 8'h1C, 8'h04, 0, 0);
        issue_exp(8'h12, 8'h34, 8'h56, 8'h36, 8'h10, 0, 0);
        issue_exp(8'hFE, 8'h01, 8'hFF, 8'hFF, 8'h00, 0, 0);
        issue_exp(8'h05, 8'h00, 8'h05, 8'hFF, 8'h00, 0, 1);
        issue_exp(8'h00, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1, 0);

        // Start during DIVIDE is dropped; operand changes mid-DIVIDE are ignored.
        issue_exp(8'h12, 8'h34, 8'h56, 8'h36, 8'h10, 0, 0);
        repeat (2) @(negedge clk);
        drive_start(8'h00, 8'h2A, 8'h00);
        bus.dividend_high = 8'h33;
        bus.dividend_low  = 8'h99;
        bus.divisor       = 8'h44;

        // Start coinciding with done is dropped; next IDLE cycle is accepted.
        issue_exp(8'h00, 8'hC8, 8'h07, 8'h1C, 8'h04, 0, 0);
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(bus.done), 1);
        drive_start(8'h05, 8'h00, 8'h05);
        issue_exp(8'h12, 8'h34, 8'h56, 8'h36, 8'h10, 0, 0);

        // Reset in the middle of a division aborts it.
        issue_exp(8'h00, 8'hC8, 8'h07, 8'h1C, 8'h04, 0, 0);
        repeat (3) @(negedge clk);
        check("busy_before_abort", int'(bus.busy), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        void'(sb.pop_back());
        @(negedge clk);
        reset_n = 1'b1;
        issue_exp(8'h00, 8'hC8, 8'h07, 8'h1C, 8'h04, 0, 0);

        // Random back-to-back sweep with in-range dividends.
        for (int i = 0; i < 1000; i++) begin
            int dv, hi, lo;
            dv = int'($urandom_range(255, 1));
            hi = int'($urandom_range(dv - 1, 0));
            lo = int'($urandom_range(255, 0));
            issue(hi, lo, dv);
        end

        wait_idle();
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Sequential unsigned restoring divider for the NEANDER-X CPU. It divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and a W-bit remainder. It is the inverse of the shift-and-add multiplier, so a DIV instruction can consume {product_high, product_low} directly. It sits beside the multiplier in the ALU and uses the same start/busy/done handshake, with one quotient bit produced per cycle.

Parameters:
WIDTH, 8, operand width in bits (quotient, remainder and divisor are WIDTH bits; dividend is 2*WIDTH bits).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  start-division pulse, sampled only in IDLE
dividend_high  input  WIDTH  dividend upper half
dividend_low  input  WIDTH  dividend lower half
divisor  input  WIDTH  divisor
quotient  output  WIDTH  quotient result
remainder  output  WIDTH  remainder result
busy  output  1  high while in DIVIDE
done  output  1  one-cycle pulse when results are valid
div_by_zero  output  1  error flag: divisor was 0
overflow  output  1  error flag: quotient does not fit in WIDTH bits

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (reset_n), no synchronous reset. While reset_n=0, state=IDLE, and quotient, remainder, count, busy, done, div_by_zero and overflow are all 0.
- States (state_t): IDLE, DIVIDE, FINISH.
- IDLE with start=1, divisor==0:
  - Next state FINISH; no DIVIDE cycles.
  - div_by_zero<=1, overflow<=0, quotient<=all ones, remainder<=dividend_low.
- IDLE with start=1, divisor!=0, dividend_high>=divisor:
  - Next state FINISH.
  - overflow<=1, div_by_zero<=0, quotient<=all ones, remainder<=dividend_low.
- IDLE with start=1, otherwise:
  - Clear both flags. R<=dividend_high, Q<=dividend_low, count<=0. Next state DIVIDE.
- Operands are sampled only at the start edge. Later input changes have no effect.
- DIVIDE step, once per cycle:
  - trial = {R,Q[MSB]} - {1'b0,divisor}, WIDTH+1 bits.
  - If trial is non-negative (MSB=0): R<=trial[WIDTH-1:0], Q<={Q[WIDTH-2:0],1}.
  - Else: R<={R[WIDTH-2:0],Q[MSB]}, Q<={Q[WIDTH-2:0],0}.
  - count<=count+1. After the step with count==WIDTH-1, go to FINISH.
  - R<divisor holds throughout, so R fits in WIDTH bits.
- quotient=Q and remainder=R. They update during DIVIDE and are valid when done=1.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Results and flags hold until the next accepted start.
- Latency:
  - Start accepted at edge k gives busy=1 for cycles k..k+WIDTH-1 and done=1 in cycle k+WIDTH. IDLE is reached after edge k+WIDTH+1.
  - Error cases give done=1 in cycle k, i.e. the cycle right after the start edge, with busy never asserted.
- start while in DIVIDE or FINISH is ignored; no queuing. start in the same cycle as done is also ignored. The earliest restart is the first IDLE cycle.
- busy and done are never high together.
- reset_n low mid-division aborts immediately to the reset values. No done pulse is issued for the aborted operation.
- count is wide enough for WIDTH (clog2(WIDTH)+1 bits). No wrap-around within an operation.

Decomposition:
- Package neander_div_pkg: state_t enum (IDLE=2'b00, DIVIDE=2'b01, FINISH=2'b10). FSM encoding matches the multiplier.
- No sub-module. The trial subtract/shift is one always_comb block inside the divider.

Test Plan:
- Basic: hi=0x00, lo=0xC8 (200), divisor=0x07 -> after 8 busy cycles, done=1 with quotient=0x1C (28), remainder=0x04, both flags 0.
- 16/8 case: hi=0x12, lo=0x34, divisor=0x56 -> quotient=0x36, remainder=0x10. Assert busy is exactly 8 cycles and done is exactly 1 cycle.
- Max and errors:
  - 0xFE01/0xFF -> quotient=0xFF, remainder=0x00, no overflow.
  - 0x0500/0x05 -> overflow=1, quotient=0xFF, remainder=0x00, done in the cycle after start.
  - divisor=0 with lo=0x2A -> div_by_zero=1, quotient=0xFF, remainder=0x2A.
- Handshake:
  - Pulse start again at busy cycle 3 with different operands -> ignored, first result is unchanged.
  - Start on the first IDLE cycle after done -> accepted.
  - Change operand inputs mid-DIVIDE -> result is unaffected.
- Reset: assert reset_n=0 in busy cycle 4 -> all outputs are 0 immediately and state is IDLE. After release, a new 200/7 yields 28 r 4.
- Randomised back-to-back sweep: 1000 vectors with dividend_high<divisor -> quotient*divisor+remainder equals the dividend and remainder<divisor.
